// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the CPU memory-port arbiter.
// Holds the FSM/owner enums and the memory-wait decode used by the perf counters.
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RWAIT = 2'd2,
        ROUT  = 2'd3
    } arb_state_t;

    typedef enum logic {
        INST = 1'b0,
        DATA = 1'b1
    } arb_owner_t;

    // True for every cycle the arbiter is blocked waiting on the memory side.
    function automatic logic mem_wait_cycle(input arb_state_t state,
                                            input logic       req_ack,
                                            input logic       rvalid);
        return ((state == REQ) && !req_ack) || ((state == RWAIT) && !rvalid);
    endfunction

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// Grant and memory-stall counters for the memory-port arbiter.
// Only instantiated when ARB_PERF_CNT_EN is defined; all counters wrap modulo 2^32.
module mem_arb_perf_cnt
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_inst_grant,
    input  logic              i_data_grant,
    input  logic              i_stall,
    output logic [DATA_W-1:0] o_inst_grants,
    output logic [DATA_W-1:0] o_data_grants,
    output logic [DATA_W-1:0] o_stall_cycles
);

    logic [DATA_W-1:0] r_inst_grants;
    logic [DATA_W-1:0] r_data_grants;
    logic [DATA_W-1:0] r_stall_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inst_grants  <= '0;
            r_data_grants  <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (i_inst_grant) r_inst_grants  <= r_inst_grants + 1'b1;
            if (i_data_grant) r_data_grants  <= r_data_grants + 1'b1;
            if (i_stall)      r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign o_inst_grants  = r_inst_grants;
    assign o_data_grants  = r_data_grants;
    assign o_stall_cycles = r_stall_cycles;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction-fetch and data channels, one transaction at a time.
// Define ARB_PERF_CNT_EN to add the perf_* grant/stall counter outputs.
module mem_port_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_req_valid,
    output logic              inst_req_ack,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_rvalid,
    input  logic              inst_rack,

    input  logic [ADDR_W-1:0] data_addr,
    input  logic              data_wen,
    input  logic              data_ren,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic [STRB_W-1:0] data_wstrb,
    output logic              data_req_ack,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_rvalid,
    input  logic              data_rack,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_req_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              mem_rack
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [DATA_W-1:0] perf_inst_grants,
    output logic [DATA_W-1:0] perf_data_grants,
    output logic [DATA_W-1:0] perf_stall_cycles
`endif
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    arb_owner_t        r_owner;

    logic [ADDR_W-1:0] r_addr;
    logic              r_wen;
    logic              r_ren;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              r_inst_req_ack;
    logic              r_data_req_ack;
    logic [DATA_W-1:0] r_inst_rdata;
    logic [DATA_W-1:0] r_data_rdata;

    logic              w_data_pending;
    logic              w_accept_data;
    logic              w_accept_inst;
    logic              w_owner_rack;

    assign w_data_pending = data_wen | data_ren;
    assign w_owner_rack   = (r_owner == DATA) ? data_rack : inst_rack;

    // Data wins over fetch; a write never waits for a response phase.
    always_comb begin
        w_state_nxt   = r_state;
        w_accept_data = 1'b0;
        w_accept_inst = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_data_pending) begin
                    w_accept_data = 1'b1;
                    w_state_nxt   = REQ;
                end else if (inst_req_valid) begin
                    w_accept_inst = 1'b1;
                    w_state_nxt   = REQ;
                end
            end
            REQ: begin
                if (mem_req_ack) begin
                    w_state_nxt = r_wen ? IDLE : RWAIT;
                end
            end
            RWAIT: begin
                if (mem_rvalid) begin
                    w_state_nxt = ROUT;
                end
            end
            ROUT: begin
                if (w_owner_rack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_owner        <= INST;
            r_addr         <= '0;
            r_wen          <= 1'b0;
            r_ren          <= 1'b0;
            r_wdata        <= '0;
            r_wstrb        <= '0;
            r_inst_req_ack <= 1'b0;
            r_data_req_ack <= 1'b0;
            r_inst_rdata   <= '0;
            r_data_rdata   <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_inst_req_ack <= w_accept_inst;
            r_data_req_ack <= w_accept_data;

            // A simultaneous wen+ren is treated as a plain write.
            if (w_accept_data) begin
                r_owner <= DATA;
                r_addr  <= data_addr;
                r_wen   <= data_wen;
                r_ren   <= data_ren & ~data_wen;
                r_wdata <= data_wdata;
                r_wstrb <= data_wstrb;
            end else if (w_accept_inst) begin
                r_owner <= INST;
                r_addr  <= inst_addr;
                r_wen   <= 1'b0;
                r_ren   <= 1'b1;
                r_wstrb <= '0;
            end

            if ((r_state == RWAIT) && mem_rvalid) begin
                if (r_owner == DATA) begin
                    r_data_rdata <= mem_rdata;
                end else begin
                    r_inst_rdata <= mem_rdata;
                end
            end
        end
    end

    assign inst_req_ack = r_inst_req_ack;
    assign data_req_ack = r_data_req_ack;
    assign inst_rdata   = r_inst_rdata;
    assign data_rdata   = r_data_rdata;
    assign inst_rvalid  = (r_state == ROUT) && (r_owner == INST);
    assign data_rvalid  = (r_state == ROUT) && (r_owner == DATA);

    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign mem_wstrb    = r_wstrb;
    assign mem_wen      = (r_state == REQ) && r_wen;
    assign mem_ren      = (r_state == REQ) && r_ren;
    assign mem_rack     = (r_state == RWAIT);

`ifdef ARB_PERF_CNT_EN
    logic w_mem_stall;

    assign w_mem_stall = mem_wait_cycle(r_state, mem_req_ack, mem_rvalid);

    mem_arb_perf_cnt u_perf_cnt (
        .clk            (clk),
        .rst            (rst),
        .i_inst_grant   (r_inst_req_ack),
        .i_data_grant   (r_data_req_ack),
        .i_stall        (w_mem_stall),
        .o_inst_grants  (perf_inst_grants),
        .o_data_grants  (perf_data_grants),
        .o_stall_cycles (perf_stall_cycles)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; the bench plays both CPU and memory.
// Define ARB_PERF_CNT_EN to also exercise the performance counters.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_addr;
    logic        inst_req_valid;
    logic        inst_req_ack;
    logic [31:0] inst_rdata;
    logic        inst_rvalid;
    logic        inst_rack;
    logic [31:0] data_addr;
    logic        data_wen;
    logic        data_ren;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_req_ack;
    logic [31:0] data_rdata;
    logic        data_rvalid;
    logic        data_rack;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic        mem_ren;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_req_ack;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        mem_rack;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_inst_grants;
    logic [31:0] perf_data_grants;
    logic [31:0] perf_stall_cycles;
`endif

    int vectors     = 0;
    int miscompares = 0;

    mem_port_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .inst_addr      (inst_addr),
        .inst_req_valid (inst_req_valid),
        .inst_req_ack   (inst_req_ack),
        .inst_rdata     (inst_rdata),
        .inst_rvalid    (inst_rvalid),
        .inst_rack      (inst_rack),
        .data_addr      (data_addr),
        .data_wen       (data_wen),
        .data_ren       (data_ren),
        .data_wdata     (data_wdata),
        .data_wstrb     (data_wstrb),
        .data_req_ack   (data_req_ack),
        .data_rdata     (data_rdata),
        .data_rvalid    (data_rvalid),
        .data_rack      (data_rack),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_ren        (mem_ren),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_req_ack    (mem_req_ack),
        .mem_rdata      (mem_rdata),
        .mem_rvalid     (mem_rvalid),
        .mem_rack       (mem_rack)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_inst_grants  (perf_inst_grants),
        .perf_data_grants  (perf_data_grants),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic        instValid,
                                 input logic [31:0] iAddr,
                                 input logic        wen,
                                 input logic        ren,
                                 input logic [31:0] dAddr,
                                 input logic [31:0] wdata,
                                 input logic [3:0]  strb);
        inst_req_valid = instValid;
        inst_addr      = iAddr;
        data_wen       = wen;
        data_ren       = ren;
        data_addr      = dAddr;
        data_wdata     = wdata;
        data_wstrb     = strb;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ":instReqAck"}, {31'd0, inst_req_ack}, 32'd0);
        checkOutput({tag, ":dataReqAck"}, {31'd0, data_req_ack}, 32'd0);
        checkOutput({tag, ":instRvalid"}, {31'd0, inst_rvalid}, 32'd0);
        checkOutput({tag, ":dataRvalid"}, {31'd0, data_rvalid}, 32'd0);
        checkOutput({tag, ":memWen"}, {31'd0, mem_wen}, 32'd0);
        checkOutput({tag, ":memRen"}, {31'd0, mem_ren}, 32'd0);
        checkOutput({tag, ":memRack"}, {31'd0, mem_rack}, 32'd0);
        checkOutput({tag, ":memAddr"}, mem_addr, 32'd0);
        checkOutput({tag, ":memWdata"}, mem_wdata, 32'd0);
        checkOutput({tag, ":memWstrb"}, {28'd0, mem_wstrb}, 32'd0);
        checkOutput({tag, ":instRdata"}, inst_rdata, 32'd0);
        checkOutput({tag, ":dataRdata"}, data_rdata, 32'd0);
    endtask

    // Full read on one channel; stray mem_rvalid during REQ must be ignored.
    task automatic readTxn(input bit isData, input logic [31:0] addr, input logic [31:0] rdata,
                           input int reqWait, input int rspWait, input int rackWait,
                           input string tag);
        if (isData) applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, addr, 32'd0, 4'd0);
        else        applyStimulus(1'b1, addr, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        tick();
        checkOutput({tag, ":ack"}, {31'd0, isData ? data_req_ack : inst_req_ack}, 32'd1);
        checkOutput({tag, ":otherAck"}, {31'd0, isData ? inst_req_ack : data_req_ack}, 32'd0);
        checkOutput({tag, ":memAddr"}, mem_addr, addr);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        for (int i = 0; i < reqWait; i++) begin
            checkOutput({tag, ":renHold"}, {31'd0, mem_ren}, 32'd1);
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hBAD0_BAD0;
            tick();
        end
        mem_rvalid = 1'b0;
        checkOutput({tag, ":ren"}, {31'd0, mem_ren}, 32'd1);
        checkOutput({tag, ":wen"}, {31'd0, mem_wen}, 32'd0);
        mem_req_ack = 1'b1;
        tick();
        mem_req_ack = 1'b0;
        checkOutput({tag, ":renDrop"}, {31'd0, mem_ren}, 32'd0);
        for (int i = 0; i < rspWait; i++) begin
            checkOutput({tag, ":earlyRvalid"}, {31'd0, isData ? data_rvalid : inst_rvalid}, 32'd0);
            tick();
        end
        checkOutput({tag, ":rack"}, {31'd0, mem_rack}, 32'd1);
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        tick();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hFFFF_FFFF;
        for (int i = 0; i <= rackWait; i++) begin
            checkOutput({tag, ":rvalid"}, {31'd0, isData ? data_rvalid : inst_rvalid}, 32'd1);
            checkOutput({tag, ":rdata"}, isData ? data_rdata : inst_rdata, rdata);
            checkOutput({tag, ":otherRvalid"}, {31'd0, isData ? inst_rvalid : data_rvalid}, 32'd0);
            checkOutput({tag, ":noRen"}, {31'd0, mem_ren}, 32'd0);
            checkOutput({tag, ":rackOff"}, {31'd0, mem_rack}, 32'd0);
            if (i == rackWait) begin
                if (isData) data_rack = 1'b1;
                else        inst_rack = 1'b1;
            end
            tick();
        end
        data_rack = 1'b0;
        inst_rack = 1'b0;
        checkOutput({tag, ":rvalidDrop"}, {31'd0, isData ? data_rvalid : inst_rvalid}, 32'd0);
    endtask

    task automatic storeTxn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                            input int ackWait, input bit alsoRen, input string tag);
        applyStimulus(1'b0, 32'd0, 1'b1, alsoRen, addr, wdata, strb);
        tick();
        checkOutput({tag, ":ack"}, {31'd0, data_req_ack}, 32'd1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        for (int i = 0; i <= ackWait; i++) begin
            checkOutput({tag, ":wen"}, {31'd0, mem_wen}, 32'd1);
            checkOutput({tag, ":ren"}, {31'd0, mem_ren}, 32'd0);
            checkOutput({tag, ":addr"}, mem_addr, addr);
            checkOutput({tag, ":wdata"}, mem_wdata, wdata);
            checkOutput({tag, ":wstrb"}, {28'd0, mem_wstrb}, {28'd0, strb});
            if (i == ackWait) mem_req_ack = 1'b1;
            tick();
        end
        mem_req_ack = 1'b0;
        checkOutput({tag, ":wenDrop"}, {31'd0, mem_wen}, 32'd0);
        checkOutput({tag, ":noRack"}, {31'd0, mem_rack}, 32'd0);
        checkOutput({tag, ":noRvalid"}, {31'd0, data_rvalid}, 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        inst_rack   = 1'b0;
        data_rack   = 1'b0;
        mem_req_ack = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = 32'd0;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        tick();
        tick();
        checkResetValues("por");
        rst = 1'b0;
        tick();

        readTxn(1'b0, 32'h0000_0010, 32'h2401_0005, 0, 0, 0, "fetchZeroWait");

        // Simultaneous fetch and load: load goes first, fetch only after data_rack.
        applyStimulus(1'b1, 32'h0000_0020, 1'b0, 1'b1, 32'h0000_0100, 32'd0, 4'd0);
        tick();
        checkOutput("simul:dataAck", {31'd0, data_req_ack}, 32'd1);
        checkOutput("simul:instAck", {31'd0, inst_req_ack}, 32'd0);
        checkOutput("simul:memAddr", mem_addr, 32'h0000_0100);
        checkOutput("simul:memRen", {31'd0, mem_ren}, 32'd1);
        applyStimulus(1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        mem_req_ack = 1'b1;
        tick();
        mem_req_ack = 1'b0;
        checkOutput("simul:instAckRwait", {31'd0, inst_req_ack}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hA5A5_0100;
        tick();
        mem_rvalid = 1'b0;
        checkOutput("simul:dataRvalid", {31'd0, data_rvalid}, 32'd1);
        checkOutput("simul:dataRdata", data_rdata, 32'hA5A5_0100);
        checkOutput("simul:instRvalid", {31'd0, inst_rvalid}, 32'd0);
        checkOutput("simul:instAckRout", {31'd0, inst_req_ack}, 32'd0);
        data_rack = 1'b1;
        tick();
        data_rack = 1'b0;
        checkOutput("simul:instAckIdle", {31'd0, inst_req_ack}, 32'd0);
        checkOutput("simul:dataRvalidDrop", {31'd0, data_rvalid}, 32'd0);
        tick();
        checkOutput("simul:instAckLate", {31'd0, inst_req_ack}, 32'd1);
        checkOutput("simul:instMemAddr", mem_addr, 32'h0000_0020);
        checkOutput("simul:instMemRen", {31'd0, mem_ren}, 32'd1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        mem_req_ack = 1'b1;
        tick();
        mem_req_ack = 1'b0;
        mem_rvalid  = 1'b1;
        mem_rdata   = 32'h3C01_0020;
        tick();
        mem_rvalid = 1'b0;
        checkOutput("simul:instRvalidLate", {31'd0, inst_rvalid}, 32'd1);
        checkOutput("simul:instRdata", inst_rdata, 32'h3C01_0020);
        checkOutput("simul:dataRdataHeld", data_rdata, 32'hA5A5_0100);
        inst_rack = 1'b1;
        tick();
        inst_rack = 1'b0;

        storeTxn(32'h0000_0200, 32'hDEAD_BEEF, 4'b0011, 3, 1'b0, "store");
        readTxn(1'b0, 32'h0000_0040, 32'h8C01_0000, 0, 1, 0, "fetchAfterStore");
        checkOutput("store:wdataHold", mem_wdata, 32'hDEAD_BEEF);

        storeTxn(32'h0000_0204, 32'h1122_3344, 4'b1111, 0, 1'b1, "wenRen");
        readTxn(1'b1, 32'h0000_0300, 32'h5555_AAAA, 2, 1, 5, "backpressure");

        // Reset while waiting for the read response.
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0400, 32'd0, 4'd0);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        mem_req_ack = 1'b1;
        tick();
        mem_req_ack = 1'b0;
        checkOutput("rstMid:rackBefore", {31'd0, mem_rack}, 32'd1);
        #2 rst = 1'b1;
        #1;
        checkResetValues("rstMid");
        tick();
        rst = 1'b0;
        tick();
        readTxn(1'b0, 32'h0000_0000, 32'h0800_0000, 0, 0, 0, "fetchAfterRst");

`ifdef ARB_PERF_CNT_EN
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checkOutput("perf:instReset", perf_inst_grants, 32'd0);
        checkOutput("perf:stallReset", perf_stall_cycles, 32'd0);
        for (int i = 0; i < 3; i++) begin
            readTxn(1'b0, 32'h0000_1000 + 32'(i) * 32'd4, 32'h1000_0000 + 32'(i), 1, 0, 0, "perfFetch");
        end
        for (int i = 0; i < 2; i++) begin
            readTxn(1'b1, 32'h0000_2000 + 32'(i) * 32'd4, 32'h2000_0000 + 32'(i), 1, 0, 0, "perfLoad");
        end
        checkOutput("perf:instGrants", perf_inst_grants, 32'd3);
        checkOutput("perf:dataGrants", perf_data_grants, 32'd2);
        checkOutput("perf:stallCycles", perf_stall_cycles, 32'd5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one memory port between the CPU's instruction-fetch and data-memory channels. Each request is accepted, forwarded to the memory, and its read data is routed back to the requester that issued it. Sits between `mips_cpu` and the unified memory or bus interface, and carries exactly one transaction at a time.

## Interface
- No parameters. Address and data width are 32, strobe width is 4.
- `clk  in  1` — system clock; all state updates on the rising edge.
- `rst  in  1` — reset, asynchronous, active-high.
- `inst_addr  in  32` — fetch address.
- `inst_req_valid  in  1` — fetch request is pending.
- `inst_req_ack  out  1` — one-cycle pulse when the fetch request is captured.
- `inst_rdata  out  32` — fetched word.
- `inst_rvalid  out  1` — `inst_rdata` is valid.
- `inst_rack  in  1` — CPU accepts `inst_rdata`.
- `data_addr  in  32` — data address, word-aligned.
- `data_wen  in  1` — store request.
- `data_ren  in  1` — load request.
- `data_wdata  in  32` — store data.
- `data_wstrb  in  4` — store byte strobes.
- `data_req_ack  out  1` — one-cycle pulse when the data request is captured.
- `data_rdata  out  32` — load data.
- `data_rvalid  out  1` — `data_rdata` is valid.
- `data_rack  in  1` — CPU accepts `data_rdata`.
- `mem_addr  out  32`, `mem_wen  out  1`, `mem_ren  out  1`, `mem_wdata  out  32`, `mem_wstrb  out  4` — request to memory.
- `mem_req_ack  in  1` — memory accepts the request.
- `mem_rdata  in  32`, `mem_rvalid  in  1` — read response from memory.
- `mem_rack  out  1` — arbiter accepts the read response.

## Operation
- FSM has four states: IDLE, REQ, RWAIT, ROUT. An `owner` register (INST or DATA) records whose transaction is in flight.
- **IDLE**
  - A data request is pending when `data_wen | data_ren` is high.
  - Arbitration is fixed priority: data > inst.
  - The winner's address, wen, ren, wdata and wstrb are latched. For an instruction, wen=0 and ren=1.
  - The winner's `*_req_ack` pulses for one cycle, `owner` is set, and the FSM moves to REQ.
  - The loser's request stays pending and is not acked.
- **REQ**
  - `mem_*` are driven from the latched registers.
  - The FSM holds until `mem_req_ack`.
  - On ack: a write goes to IDLE (stores have no response phase); a read goes to RWAIT.
- **RWAIT**
  - `mem_rack` = 1.
  - When `mem_rvalid` is seen, `mem_rdata` is captured into the response register and the FSM moves to ROUT.
- **ROUT**
  - The owner's `*_rvalid` = 1 and its `*_rdata` = the response register. The other channel's rvalid is 0.
  - On the owner's `*_rack`, the FSM goes to IDLE.
- `data_wen & data_ren` together is illegal; the arbiter performs the write only.
- `mem_wen`, `mem_ren` and `mem_rack` are 0 outside REQ and RWAIT respectively. `mem_addr` and `mem_wdata` hold their last value.

## Timing
- Reset values:
  - FSM = IDLE, `owner` = INST.
  - All `*_ack`, `*_rvalid`, `mem_wen`, `mem_ren` and `mem_rack` = 0.
  - `mem_addr`, `mem_wdata`, `mem_wstrb`, `inst_rdata` and `data_rdata` = 0.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Minimum read latency:
  - accept at edge 0;
  - `mem_ren` high during cycle 1, with `mem_req_ack` in cycle 1;
  - `mem_rvalid` in cycle 2;
  - `*_rvalid` high from cycle 3.
- Minimum write occupancy: 2 cycles from accept to IDLE.
- IDLE → REQ does not inspect `mem_req_ack`. A new request is accepted no earlier than the cycle after return to IDLE.
- `mem_rvalid` is ignored outside RWAIT.
- Reset asserted mid-transaction immediately forces the reset values and drops the in-flight transaction.

## Configuration
- `ARB_PERF_CNT_EN`
  - Defined:
    - adds outputs `perf_inst_grants`, `perf_data_grants` and `perf_stall_cycles`, each `out  32`;
    - a grant counter increments on its channel's `*_req_ack`;
    - the stall counter increments each cycle that REQ or RWAIT waits on memory;
    - all counters reset to 0 and wrap modulo 2^32.
  - Undefined: these ports and counters do not exist. Core behaviour is identical either way.

## Structure
- Package `mem_arb_pkg` holds:
  - `arb_state_t` (IDLE, REQ, RWAIT, ROUT);
  - `arb_owner_t` (INST, DATA);
  - width constants `ADDR_W` = 32, `DATA_W` = 32, `STRB_W` = 4.
- Sub-module `mem_arb_perf_cnt` holds the three counters. It is instantiated only under `ARB_PERF_CNT_EN`.

## Test plan
- **Instruction read, zero wait.** `inst_req_valid`=1, `inst_addr`=0x0000_0010, memory acks immediately and returns 0x2401_0005. Required:
  - `mem_addr`=0x10, `mem_ren`=1;
  - `inst_rvalid`=1 with 0x2401_0005 on cycle 3;
  - `data_rvalid` stays 0.
- **Simultaneous requests.** inst (0x20) and data load (0x100) in the same IDLE cycle. Required:
  - `data_req_ack` pulses first and memory sees 0x100 first;
  - inst is served only after `data_rack`.
- **Store.** `data_wen`=1, `data_addr`=0x200, `data_wdata`=0xDEAD_BEEF, `data_wstrb`=4'b0011, `mem_req_ack` delayed 3 cycles. Required:
  - `mem_wen` held for 4 cycles with stable fields;
  - FSM back in IDLE the cycle after the ack;
  - no `data_rvalid`.
- **Response backpressure.** `data_rack` held low 5 cycles in ROUT. Required:
  - `data_rvalid` and `data_rdata` stable throughout;
  - no new `mem_ren`.
- **Reset mid-transaction.** `rst` pulsed while in RWAIT. Required:
  - outputs immediately at their reset values;
  - a subsequent fetch of 0x0 completes normally.
- **Performance counters.** With `ARB_PERF_CNT_EN` defined, run 3 fetches and 2 loads with 1 wait cycle each. Required: `perf_inst_grants`=3, `perf_data_grants`=2, `perf_stall_cycles`=5.
